// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and LZB helper for the display scan controller
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int MAX_DIGITS = 4;
    localparam logic [MAX_DIGITS-1:0] COM_OFF = '1;

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    function automatic logic [MAX_DIGITS-1:0] lzb_mask(
        input logic [4*MAX_DIGITS-1:0] data,
        input int                      n_digits,
        input logic                    lzb
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zeros_above;
        mask        = '0;
        zeros_above = lzb;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n_digits) begin
                if (zeros_above && (data[4*i +: 4] == 4'd0)) begin
                    mask[i] = 1'b1;
                end else begin
                    zeros_above = 1'b0;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - digit data in, scan drive out, for the display scan controller
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 3
);
    logic                  EN;
    logic [4*N_DIGITS-1:0] DATA;
    logic                  LZB;
    logic [3:0]            DIGIT_BCD;
    logic [N_DIGITS-1:0]   COM;
    logic                  FRAME_TICK;

    modport master (
        output EN, DATA, LZB,
        input  DIGIT_BCD, COM, FRAME_TICK
    );

    modport slave (
        input  EN, DATA, LZB,
        output DIGIT_BCD, COM, FRAME_TICK
    );
endinterface

// File: rtl/scan_slot_timer.sv
// rtl/scan_slot_timer.sv - per-digit slot counter with end-of-blank and end-of-slot flags
module scan_slot_timer #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int CNT_W        = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic blank_done,
    output logic slot_end
);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clear || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Both flags mark the final cycle of their phase so the FSM switches on that edge.
    assign blank_done = (cnt == BLANK_LAST);
    assign slot_end   = (cnt == SLOT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan scheduler with snapshot and leading-zero blanking
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 3,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int CNT_W        = 16
) (
    input  logic                CLK,
    input  logic                RST,
    display_scan_ctrl_if.slave  bus
);
    localparam int IDX_W = (N_DIGITS > 2) ? 2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] COM_IDLE = COM_OFF[N_DIGITS-1:0];

    scan_state_t           state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [4*N_DIGITS-1:0] snapshot;
    logic [N_DIGITS-1:0]   blank_mask;
    logic [4*MAX_DIGITS-1:0] data_ext;
    logic [N_DIGITS-1:0]   com_lit;
    logic [3:0]            next_bcd;
    logic                  timer_clear;
    logic                  blank_done;
    logic                  slot_end;

    // The counter sits at zero while idle so the first BLANK cycle is cnt 0.
    assign timer_clear = (state == IDLE) || !bus.EN;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (timer_clear),
        .blank_done (blank_done),
        .slot_end   (slot_end)
    );

    always_comb begin
        data_ext                 = '0;
        data_ext[4*N_DIGITS-1:0] = bus.DATA;
        idx_next                 = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        next_bcd                 = snapshot[{idx_next, 2'b00} +: 4];
        com_lit                  = ~(N_DIGITS'(1) << idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            idx            <= '0;
            snapshot       <= '0;
            blank_mask     <= '0;
            bus.DIGIT_BCD  <= 4'd0;
            bus.COM        <= COM_IDLE;
            bus.FRAME_TICK <= 1'b0;
        end else if (!bus.EN) begin
            state          <= IDLE;
            idx            <= '0;
            bus.COM        <= COM_IDLE;
            bus.FRAME_TICK <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= BLANK;
                    idx            <= '0;
                    snapshot       <= bus.DATA;
                    blank_mask     <= N_DIGITS'(lzb_mask(data_ext, N_DIGITS, bus.LZB));
                    bus.DIGIT_BCD  <= bus.DATA[3:0];
                    bus.COM        <= COM_IDLE;
                    bus.FRAME_TICK <= 1'b1;
                end
                BLANK: begin
                    bus.FRAME_TICK <= 1'b0;
                    if (blank_done) begin
                        state   <= ON;
                        bus.COM <= blank_mask[idx] ? COM_IDLE : com_lit;
                    end
                end
                ON: begin
                    bus.FRAME_TICK <= 1'b0;
                    if (slot_end) begin
                        state   <= BLANK;
                        idx     <= idx_next;
                        bus.COM <= COM_IDLE;
                        // Wrapping to digit 0 starts a frame: take a fresh, tear-free copy of DATA.
                        if (idx_next == '0) begin
                            snapshot       <= bus.DATA;
                            blank_mask     <= N_DIGITS'(lzb_mask(data_ext, N_DIGITS, bus.LZB));
                            bus.DIGIT_BCD  <= bus.DATA[3:0];
                            bus.FRAME_TICK <= 1'b1;
                        end else begin
                            bus.DIGIT_BCD  <= next_bcd;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus.COM <= COM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed vector bench for display_scan_ctrl
module tb_display_scan_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic [11:0] data;
        logic        lzb;
        logic [3:0]  bcd;
        logic [2:0]  com;
        logic        tick;
    } vec_t;

    vec_t tbl[19];

    display_scan_ctrl_if #(.N_DIGITS(3)) bus();

    display_scan_ctrl #(
        .N_DIGITS     (3),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One table row covers one 8-cycle digit slot; new DATA/LZB land mid-ON.
    task automatic run_slots(input int lo, input int hi);
        for (int s = lo; s <= hi; s++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                chk($sformatf("slot%0d_c%0d_bcd", s, c), 32'(bus.DIGIT_BCD), 32'(tbl[s].bcd));
                chk($sformatf("slot%0d_c%0d_com", s, c), 32'(bus.COM),
                    (c < 2) ? 32'h7 : 32'(tbl[s].com));
                chk($sformatf("slot%0d_c%0d_tick", s, c), 32'(bus.FRAME_TICK),
                    (c == 0) ? 32'(tbl[s].tick) : 32'h0);
                if (c == 4) begin
                    bus.DATA = tbl[s].data;
                    bus.LZB  = tbl[s].lzb;
                end
            end
        end
    endtask

    initial begin
        int last_digit;
        int high_run;
        int lows;
        checks = 0;
        errors = 0;

        tbl[0]  = '{12'h123, 1'b0, 4'd3, 3'b110, 1'b1};
        tbl[1]  = '{12'h789, 1'b0, 4'd2, 3'b101, 1'b0};
        tbl[2]  = '{12'h789, 1'b0, 4'd1, 3'b011, 1'b0};
        tbl[3]  = '{12'h789, 1'b0, 4'd9, 3'b110, 1'b1};
        tbl[4]  = '{12'h789, 1'b0, 4'd8, 3'b101, 1'b0};
        tbl[5]  = '{12'h005, 1'b1, 4'd7, 3'b011, 1'b0};
        tbl[6]  = '{12'h005, 1'b1, 4'd5, 3'b110, 1'b1};
        tbl[7]  = '{12'h005, 1'b1, 4'd0, 3'b111, 1'b0};
        tbl[8]  = '{12'h050, 1'b1, 4'd0, 3'b111, 1'b0};
        tbl[9]  = '{12'h050, 1'b1, 4'd0, 3'b110, 1'b1};
        tbl[10] = '{12'h050, 1'b1, 4'd5, 3'b101, 1'b0};
        tbl[11] = '{12'h000, 1'b1, 4'd0, 3'b111, 1'b0};
        tbl[12] = '{12'h000, 1'b1, 4'd0, 3'b110, 1'b1};
        tbl[13] = '{12'h000, 1'b1, 4'd0, 3'b111, 1'b0};
        tbl[14] = '{12'h105, 1'b1, 4'd0, 3'b111, 1'b0};
        tbl[15] = '{12'h105, 1'b1, 4'd5, 3'b110, 1'b1};
        tbl[16] = '{12'h105, 1'b1, 4'd0, 3'b101, 1'b0};
        tbl[17] = '{12'h123, 1'b0, 4'd1, 3'b011, 1'b0};
        tbl[18] = '{12'h123, 1'b0, 4'd3, 3'b110, 1'b1};

        // Reset asserted with EN high: outputs idle immediately and reset wins over EN.
        rst      = 1'b1;
        bus.EN   = 1'b1;
        bus.DATA = 12'h123;
        bus.LZB  = 1'b0;
        #2;
        chk("rst_com", 32'(bus.COM), 32'h7);
        chk("rst_bcd", 32'(bus.DIGIT_BCD), 32'h0);
        chk("rst_tick", 32'(bus.FRAME_TICK), 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_en_com", 32'(bus.COM), 32'h7);
        chk("rst_en_tick", 32'(bus.FRAME_TICK), 32'h0);
        rst = 1'b0;

        // Basic scan, snapshot and leading-zero blanking frames.
        run_slots(0, 18);

        // Disable during digit 1 ON, then re-enable.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("dis_c%0d_bcd", c), 32'(bus.DIGIT_BCD), 32'h2);
            chk($sformatf("dis_c%0d_com", c), 32'(bus.COM), (c < 2) ? 32'h7 : 32'h5);
        end
        bus.EN = 1'b0;
        @(negedge clk);
        chk("dis_off_com", 32'(bus.COM), 32'h7);
        chk("dis_hold_bcd", 32'(bus.DIGIT_BCD), 32'h2);
        chk("dis_off_tick", 32'(bus.FRAME_TICK), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("dis_idle%0d_com", c), 32'(bus.COM), 32'h7);
        end
        bus.EN = 1'b1;
        @(negedge clk);
        chk("reen_tick", 32'(bus.FRAME_TICK), 32'h1);
        chk("reen_bcd", 32'(bus.DIGIT_BCD), 32'h3);
        chk("reen_com0", 32'(bus.COM), 32'h7);
        @(negedge clk);
        chk("reen_tick_off", 32'(bus.FRAME_TICK), 32'h0);
        chk("reen_com1", 32'(bus.COM), 32'h7);
        @(negedge clk);
        chk("reen_com_on", 32'(bus.COM), 32'h6);

        // Asynchronous reset between edges while a digit is lit.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_com", 32'(bus.COM), 32'h7);
        chk("arst_tick", 32'(bus.FRAME_TICK), 32'h0);
        chk("arst_bcd", 32'(bus.DIGIT_BCD), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_slots(0, 1);

        // Random stimulus with invariant monitoring on COM.
        last_digit = -1;
        high_run   = 2;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            lows = $countones(~bus.COM);
            chk("inv_onehot", 32'(lows <= 1), 32'h1);
            if (lows == 0) begin
                high_run++;
            end else begin
                for (int d = 0; d < 3; d++) begin
                    if (!bus.COM[d]) begin
                        if (last_digit >= 0 && d != last_digit) begin
                            chk("inv_gap", 32'(high_run >= 2), 32'h1);
                        end
                        last_digit = d;
                    end
                end
                high_run = 0;
            end
            bus.DATA = 12'($urandom);
            bus.LZB  = 1'($urandom_range(0, 1));
            bus.EN   = ($urandom_range(0, 40) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan scheduler for the multiplexed 7-segment display. It time-shares one BCD_7SEG decoder between N_DIGITS common-anode digits. Each frame it snapshots the packed digit word, then steps through the digits. For each digit it drives the BCD nibble, holds a blanking gap to suppress ghosting, and then asserts that digit's COM line. It replaces the free-running priority counter ahead of the 4:1 mux and decoder, and adds tear-free capture and leading-zero blanking.

Parameters:
N_DIGITS, 3, number of multiplexed digits (2..4)
SLOT_CYCLES, 50000, CLK cycles per digit slot (blank + on)
BLANK_CYCLES, 64, cycles at the start of each slot with all COM inactive; 1 <= BLANK_CYCLES < SLOT_CYCLES
CNT_W, 16, slot counter width; 2^CNT_W >= SLOT_CYCLES

Ports:
CLK  in  1  system clock, single clock domain
RST  in  1  asynchronous, active-high reset
EN  in  1  scan enable
DATA  in  4*N_DIGITS  packed BCD; DATA[3:0] = digit 0 (least significant)
LZB  in  1  leading-zero blanking enable
DIGIT_BCD  out  4  nibble for the currently selected digit, to BCD_7SEG
COM  out  N_DIGITS  digit commons, active-low; COM[i] low = digit i lit
FRAME_TICK  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed): state IDLE, COM all ones, DIGIT_BCD=0, FRAME_TICK=0, digit index=0, slot counter=0, snapshot=0.
- All outputs are registered.
- States:
  - IDLE: COM all ones.
  - BLANK: COM all ones; DIGIT_BCD already holds the new digit.
  - ON: COM[idx] low, unless that digit is blanked.
- IDLE -> BLANK(idx 0) on the first edge where EN=1.
  - Entering idx-0 BLANK loads snapshot<=DATA and the LZB mask.
  - FRAME_TICK=1 for that first BLANK cycle only.
- Slot counter runs 0..SLOT_CYCLES-1.
  - cnt 0..BLANK_CYCLES-1: BLANK.
  - cnt BLANK_CYCLES..SLOT_CYCLES-1: ON.
  - On the last ON cycle: idx<=idx+1, or wrap to 0 after N_DIGITS-1 (wrap starts a new frame with snapshot and FRAME_TICK); cnt<=0; state BLANK.
- DIGIT_BCD<=snapshot nibble[idx] on the edge entering BLANK, so it is stable BLANK_CYCLES before COM asserts.
- Frame length = N_DIGITS*SLOT_CYCLES cycles exactly.
- DATA changes mid-frame are ignored until the next frame snapshot.
- Leading-zero blanking (LZB sampled with the snapshot):
  - Scanning from digit N_DIGITS-1 downward, each digit that equals 0 and has only zero digits above it is blanked.
  - Digit 0 is never blanked.
  - A blanked digit keeps its slot timing, but its COM stays high throughout ON.
- Nibbles >9 pass through unchanged; decoding them is BCD_7SEG's job.
- Invariants:
  - At most one COM bit is low in any cycle.
  - Every COM transition between different digits is separated by >= BLANK_CYCLES cycles of all-high.
- EN deasserted in any state: the next edge enters IDLE, COM all ones, cnt=0, idx=0; DIGIT_BCD holds its value. Re-enable restarts a fresh frame at digit 0 with FRAME_TICK.
- EN=1 and RST=1 together: reset wins.

Decomposition:
- Package display_pkg holds:
  - scan state enum (IDLE, BLANK, ON);
  - COM_OFF constant (all ones);
  - a function computing the LZB mask from the packed snapshot.
- One sub-module, scan_slot_timer: slot counter with a blank_done flag and a slot_end pulse, parameterised by SLOT_CYCLES, BLANK_CYCLES and CNT_W.
- The FSM, snapshot register, index and output registers stay in display_scan_ctrl.

Test Plan:
Bench parameters for all scenarios: N_DIGITS=3, SLOT_CYCLES=8, BLANK_CYCLES=2.
1. Basic scan: RST pulse, then EN=1, DATA=12'h123, LZB=0 -> COM=3'b111 while in reset.
   - FRAME_TICK one cycle at the first BLANK.
   - DIGIT_BCD=3 with COM=3'b110 for 6 cycles, then 2/3'b101, then 1/3'b011.
   - 2-cycle all-high gap before each digit; FRAME_TICK repeats every 24 cycles.
2. Snapshot: change DATA to 12'h789 during digit-1 ON -> current frame still shows 2,1; next frame shows 9,8,7.
3. LZB: LZB=1 with DATA=12'h005 -> only COM[0] ever goes low, showing 5.
   - DATA=12'h050 -> COM[1] shows 5, COM[0] shows 0, COM[2] never low.
   - DATA=12'h000 -> only digit 0 lit.
   - DATA=12'h105 -> all three lit.
4. Disable: EN=0 mid-ON of digit 1 -> COM=3'b111 one edge later and stays; EN=1 again -> FRAME_TICK, DIGIT_BCD=digit 0, COM[0] low after 2 cycles.
5. Async reset: assert RST between clock edges during ON -> COM=3'b111 and FRAME_TICK=0 before the next edge; after release, behaviour matches scenario 1.
6. Invariant monitor over 1000 random-DATA/LZB/EN cycles -> never more than one COM bit low; every change of active digit preceded by >=2 cycles of 3'b111.
